// File: rtl/io_bcd_display.sv
// rtl/io_bcd_display.sv - memory-mapped 32-bit to 10-digit BCD display converter
//
// Purpose: a store to VALUE latches a 32-bit number and converts it to ten BCD
// digits with a sequential double-dabble engine, one bit per clock. The latched
// digits and a sign bit drive the seven-segment hex drivers directly.
//
// Optional feature macro: DISPLAY_SIGNED_EN
//   defined   - VALUE is two's complement; negatives display as magnitude + sign
//   undefined - VALUE is unsigned; sign is tied to 0
//
// Ports:
//   clk        in  1              system clock, rising edge
//   rst        in  1              asynchronous active-high reset
//   addressIO  in  IO_ADDR_BITS   IO word address (0 VALUE, 1 STATUS, 2 BCD_LO, 3 BCD_HI)
//   dataInIO   in  32             write data
//   wEnIO      in  1              write strobe
//   dataOutIO  out 32             combinational read data
//   digits     out 40             10 BCD digits, digit k at [4k+3:4k]
//   sign       out 1              displayed value is negative
//   busy       out 1              conversion in progress
//   valid      out 1              digits/sign hold a completed conversion
module io_bcd_display #(
  parameter int IO_ADDR_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IO_ADDR_BITS-1:0] addressIO,
  input  logic [31:0]             dataInIO,
  input  logic                    wEnIO,
  output logic [31:0]             dataOutIO,
  output logic [39:0]             digits,
  output logic                    sign,
  output logic                    busy,
  output logic                    valid
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [31:0] mag_q, mag_d;
  logic [39:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        pend_sign_q, pend_sign_d;
  logic [39:0] digits_q, digits_d;
  logic        sign_q, sign_d;
  logic        valid_q, valid_d;

  logic        wr_value;
  logic [31:0] in_mag;
  logic        in_sign;
  logic [39:0] acc_adj;
  logic [39:0] acc_shift;

  assign wr_value = wEnIO && (addressIO == IO_ADDR_BITS'(0));

`ifdef DISPLAY_SIGNED_EN
  // Two's-complement negate; 0x80000000 maps to itself, which read as
  // unsigned is exactly 2147483648.
  assign in_mag  = dataInIO[31] ? (~dataInIO + 32'd1) : dataInIO;
  assign in_sign = dataInIO[31];
`else
  assign in_mag  = dataInIO;
  assign in_sign = 1'b0;
`endif

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift so
  // that the shift carries correctly into the next decimal digit.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < 10; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
  end

  assign acc_shift = {acc_adj[38:0], mag_q[31]};

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pend_sign_d = pend_sign_q;
    digits_d    = digits_q;
    sign_d      = sign_q;
    valid_d     = valid_q;

    // A new write always wins, so it also aborts a conversion in flight.
    if (wr_value) begin
      value_d     = dataInIO;
      mag_d       = in_mag;
      acc_d       = 40'd0;
      cnt_d       = 5'd0;
      pend_sign_d = in_sign;
      state_d     = SHIFT;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          acc_d = acc_shift;
          mag_d = {mag_q[30:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            digits_d = acc_shift;
            sign_d   = pend_sign_q;
            valid_d  = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      value_q     <= 32'd0;
      mag_q       <= 32'd0;
      acc_q       <= 40'd0;
      cnt_q       <= 5'd0;
      pend_sign_q <= 1'b0;
      digits_q    <= 40'd0;
      sign_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pend_sign_q <= pend_sign_d;
      digits_q    <= digits_d;
      sign_q      <= sign_d;
      valid_q     <= valid_d;
    end
  end

  assign digits = digits_q;
  assign sign   = sign_q;
  assign busy   = (state_q == SHIFT);
  assign valid  = valid_q;

  always_comb begin
    dataOutIO = 32'd0;
    if (addressIO == IO_ADDR_BITS'(0)) begin
      dataOutIO = value_q;
    end else if (addressIO == IO_ADDR_BITS'(1)) begin
      dataOutIO = {30'd0, valid_q, busy};
    end else if (addressIO == IO_ADDR_BITS'(2)) begin
      dataOutIO = digits_q[31:0];
    end else if (addressIO == IO_ADDR_BITS'(3)) begin
      dataOutIO = {23'd0, sign_q, digits_q[39:32]};
    end
  end

endmodule

// File: tb/tb_io_bcd_display.sv
// tb/tb_io_bcd_display.sv - self-checking bench for io_bcd_display
module tb_io_bcd_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addressIO = 4'd0;
  logic [31:0] dataInIO = 32'd0;
  logic        wEnIO = 1'b0;
  logic [31:0] dataOutIO;
  logic [39:0] digits;
  logic        sign;
  logic        busy;
  logic        valid;

  int checks = 0;
  int errors = 0;

  // Reference state: what the display should currently show.
  logic [31:0] m_value  = 32'd0;
  logic [39:0] m_digits = 40'd0;
  logic        m_sign   = 1'b0;
  logic        m_valid  = 1'b0;

  io_bcd_display #(.IO_ADDR_BITS(4)) dut (
    .clk(clk), .rst(rst), .addressIO(addressIO), .dataInIO(dataInIO),
    .wEnIO(wEnIO), .dataOutIO(dataOutIO), .digits(digits), .sign(sign),
    .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decimal digits by plain division, independent of any shift-add scheme.
  function automatic logic [39:0] to_bcd(input longint unsigned m);
    logic [39:0] d = 40'd0;
    for (int k = 0; k < 10; k++) begin
      d[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return d;
  endfunction

  function automatic longint unsigned ref_mag(input logic [31:0] v);
`ifdef DISPLAY_SIGNED_EN
    longint s = longint'($signed(v));
    return (s < 0) ? longint'(-s) : longint'(s);
`else
    return longint'({32'd0, v});
`endif
  endfunction

  function automatic logic ref_sign(input logic [31:0] v);
`ifdef DISPLAY_SIGNED_EN
    return v[31];
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle write; also checks the same-cycle read of VALUE is old.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] v);
    addressIO = a;
    dataInIO  = v;
    wEnIO     = 1'b1;
    #1;
    if (a == 4'd0) chk("value_read_during_write", {32'd0, dataOutIO}, {32'd0, m_value});
    step();
    wEnIO = 1'b0;
    if (a == 4'd0) m_value = v;
  endtask

  task automatic chk_regs(input string tag);
    addressIO = 4'd0; #1; chk({tag, "_rd_value"},  {32'd0, dataOutIO}, {32'd0, m_value});
    addressIO = 4'd1; #1; chk({tag, "_rd_status"}, {32'd0, dataOutIO}, {62'd0, m_valid, busy});
    addressIO = 4'd2; #1; chk({tag, "_rd_bcd_lo"}, {32'd0, dataOutIO}, {32'd0, m_digits[31:0]});
    addressIO = 4'd3; #1; chk({tag, "_rd_bcd_hi"}, {32'd0, dataOutIO}, {55'd0, m_sign, m_digits[39:32]});
    addressIO = 4'd7; #1; chk({tag, "_rd_other"},  {32'd0, dataOutIO}, 64'd0);
  endtask

  // Full conversion: write, watch 31 busy cycles with the old display held,
  // then check the published result at write edge + 32.
  task automatic convert(input string tag, input logic [31:0] v);
    bool_hold_ok_t: begin end
    bus_write(4'd0, v);
    chk({tag, "_busy_after_write"}, {63'd0, busy}, 64'd1);
    for (int c = 1; c < 32; c++) begin
      step();
      if (c == 31) begin
        chk({tag, "_busy_before_done"}, {63'd0, busy}, 64'd1);
        chk({tag, "_digits_held"}, {24'd0, digits}, {24'd0, m_digits});
      end
    end
    step();
    m_digits = to_bcd(ref_mag(v));
    m_sign   = ref_sign(v);
    m_valid  = 1'b1;
    chk({tag, "_digits"}, {24'd0, digits}, {24'd0, m_digits});
    chk({tag, "_sign"},   {63'd0, sign},   {63'd0, m_sign});
    chk({tag, "_valid"},  {63'd0, valid},  64'd1);
    chk({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    chk_regs(tag);
  endtask

  initial begin
    logic [31:0] r;

    // Reset and idle read
    #2;
    for (int a = 0; a < 4; a++) begin
      addressIO = 4'(a); #1;
      chk("reset_read", {32'd0, dataOutIO}, 64'd0);
    end
    chk("reset_busy",   {63'd0, busy},   64'd0);
    chk("reset_valid",  {63'd0, valid},  64'd0);
    chk("reset_digits", {24'd0, digits}, 64'd0);
    step();
    rst = 1'b0;
    step();
    chk_regs("idle");

    // Directed values, including boundaries
    convert("basic_1234", 32'd1234);
    chk("basic_1234_exact", {24'd0, digits}, {24'd0, 40'h00_0000_1234});
    convert("min_neg", 32'h8000_0000);
    chk("min_neg_exact", {24'd0, digits}, {24'd0, 40'h21_4748_3648});
    convert("all_ones", 32'hFFFF_FFFF);
    convert("zero", 32'd0);
    convert("max_pos", 32'h7FFF_FFFF);

    // Ignored writes: read-only and unmapped addresses change nothing
    bus_write(4'd1, 32'hFFFF_FFFF);
    bus_write(4'd2, 32'h1234_5678);
    bus_write(4'd9, 32'hDEAD_BEEF);
    chk("ignored_busy", {63'd0, busy}, 64'd0);
    chk_regs("ignored");

    // Randomized conversions
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      if (i == 0) r = r & 32'h0000_FFFF;
      convert("random", r);
    end

    // Restart: 99 then 7 ten cycles later; 99 never appears
    bus_write(4'd0, 32'd99);
    for (int c = 0; c < 9; c++) begin
      step();
      chk("restart_hold_a", {24'd0, digits}, {24'd0, m_digits});
    end
    convert("restart_7", 32'd7);
    chk("restart_exact", {24'd0, digits}, 64'h7);

    // Async reset mid-conversion
    bus_write(4'd0, 32'd5555);
    for (int c = 0; c < 14; c++) step();
    #2;
    rst = 1'b1;
    #1;
    m_value = 32'd0; m_digits = 40'd0; m_sign = 1'b0; m_valid = 1'b0;
    chk("arst_digits", {24'd0, digits}, 64'd0);
    chk("arst_sign",   {63'd0, sign},   64'd0);
    chk("arst_busy",   {63'd0, busy},   64'd0);
    chk("arst_valid",  {63'd0, valid},  64'd0);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) step();
    chk("arst_valid_stays", {63'd0, valid}, 64'd0);
    chk_regs("arst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bcd_display.md
# io_bcd_display

Memory-mapped IO peripheral on the IO side of the memory controller. It is driven by `addressIO`/`dataInIO`/`wEnIO` and answers on `dataOutIO`. A store to its value register latches a 32-bit number and converts it to 10 BCD digits with a sequential double-dabble engine, one bit per clock. The latched digits plus a sign bit feed the seven-segment hex drivers directly, which replaces per-digit combinational division.

## Interface
- `IO_ADDR_BITS`, default 4: width of the IO word address; must match the memory controller.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `addressIO` in IO_ADDR_BITS: IO register select.
- `dataInIO` in 32: write data.
- `wEnIO` in 1: write strobe, sampled on the rising edge of `clk`.
- `dataOutIO` out 32: read data, combinational from `addressIO`.
- `digits` out 40: 10 BCD digits; digit k is at `[4k+3:4k]`, digit 0 is least significant.
- `sign` out 1: 1 when the displayed value is negative.
- `busy` out 1: conversion in progress.
- `valid` out 1: `digits`/`sign` hold a completed conversion.

## Operation
- Register map (word address):
  - 0 VALUE: read/write; read returns the last written value.
  - 1 STATUS: read-only, `{30'b0, valid, busy}`.
  - 2 BCD_LO: read-only, digits 7..0.
  - 3 BCD_HI: read-only, `{23'b0, sign, digits 9..8}`.
  - Other addresses read 0; writes to them are ignored.
- Writes to STATUS, BCD_LO or BCD_HI are ignored.
- FSM has two states, IDLE and SHIFT.
- A write to VALUE in either state:
  - Stores VALUE and computes magnitude: `|v|` when the value is treated as signed and `v[31]` is 1, otherwise `v`. Magnitude is 32-bit unsigned; -2^31 gives 2147483648.
  - Loads magnitude into the shift register, clears the 40-bit BCD accumulator and the bit counter, and latches the pending sign.
  - Enters SHIFT.
- SHIFT, each cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then `{acc, mag}` shifts left by 1.
  - Counter increments.
- After the 32nd shift:
  - `digits` ← accumulator, `sign` ← pending sign.
  - `valid` ← 1, `busy` ← 0, state goes to IDLE.
- A write to VALUE during SHIFT aborts the current conversion and restarts it with the new value. `digits`/`sign`/`valid` keep their previous contents until the new conversion completes.
- The accumulator never overflows: 2^32-1 needs 10 digits.

## Timing
- Reset values: state IDLE, VALUE=0, `digits`=0, `sign`=0, `busy`=0, `valid`=0, counter=0. `dataOutIO` is then 0 for every address.
- Reset asserted mid-conversion returns everything immediately to the reset values. No partial result is published.
- Write at rising edge N:
  - `busy`=1 after edge N.
  - `digits`, `sign`, `valid`=1 and `busy`=0 update at edge N+32.
- Latency is 32 cycles from the write edge.
- Throughput is one conversion per 32 cycles. Back-to-back writes restart the conversion, so only the last write is displayed, 32 cycles after it.
- `dataOutIO` has zero cycles of latency. A read of VALUE in the same cycle as a write to it returns the old value.
- STATUS read at edge N+32 reflects the pre-edge state; `busy` is still 1 in the cycle before that edge.

## Configuration
- Macro: `DISPLAY_SIGNED_EN`.
- Defined:
  - VALUE is two's complement.
  - Negative values convert as a magnitude.
  - `sign` = `v[31]`.
- Undefined:
  - VALUE is unsigned, with no negation logic.
  - `sign` is tied to 0.
  - 0xFFFFFFFF displays 4294967295.

## Test plan
- Reset and idle read: assert `rst`, then read addresses 0–3 → `dataOutIO`=0 each time; `busy`=0, `valid`=0, `digits`=0.
- Basic conversion: write 1234 to address 0 → `busy` high for 32 cycles, then `digits`=0x00_0000_1234, `sign`=0, `valid`=1; BCD_LO reads 0x00001234.
- Negative value, `DISPLAY_SIGNED_EN` defined: write 0x80000000 → `digits`=0x21_4748_3648, `sign`=1; BCD_HI reads 0x00000121.
  - Same write with the macro undefined → `digits`=0x21_4748_3648, `sign`=0.
- Maximum value: write 0xFFFFFFFF.
  - Signed build → `digits`=1, `sign`=1.
  - Unsigned build → `digits`=0x42_9496_7295.
- Restart: write 99, then write 7 ten cycles later → `digits` stay at the prior value until 32 cycles after the second write, then become 7. The value 99 never appears.
- Async reset mid-conversion: write 5555, pulse `rst` at cycle 15 between clock edges → all outputs are 0 immediately; `valid` stays 0 with no further writes.
